// File: rtl/sm_matrix_pkg.sv
// Shared types and constants for the 2x2 matrix-multiply RAM controller.
package sm_matrix_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, STORE, DONE} state_t;

    localparam int unsigned CSR_START_BIT = 0;
    localparam int unsigned CSR_CLR_BIT   = 1;
    localparam int unsigned CSR_DONE_BIT  = 0;
    localparam int unsigned CSR_BUSY_BIT  = 1;

    localparam logic [3:0] DEF_CSR_ADDR = 4'hF;
    localparam logic [3:0] DEF_A_BASE   = 4'h0;
    localparam logic [3:0] DEF_B_BASE   = 4'h4;
    localparam logic [3:0] DEF_C_BASE   = 4'h8;

endpackage

// File: rtl/sm_matrix_dot2.sv
// Two-term dot product a0*b0 + a1*b1, wrapped to 32 bits.
module sm_matrix_dot2
    import sm_matrix_pkg::*;
(
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic [31:0] y
);

    assign y = a0 * b0 + a1 * b1;

endmodule

// File: rtl/sm_matrix_ctrl.sv
// Arbitrates RAM port A between the system bus and a 2x2 matrix-multiply engine;
// the bus always wins, the engine retries on the next cycle.
module sm_matrix_ctrl
    import sm_matrix_pkg::*;
#(
    parameter int unsigned   AW       = 4,
    parameter logic [AW-1:0] CSR_ADDR = AW'(DEF_CSR_ADDR),
    parameter logic [AW-1:0] A_BASE   = AW'(DEF_A_BASE),
    parameter logic [AW-1:0] B_BASE   = AW'(DEF_B_BASE),
    parameter logic [AW-1:0] C_BASE   = AW'(DEF_C_BASE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bValid,
    input  logic [31:0]   bAddr,
    input  logic          bWrite,
    input  logic [31:0]   bWData,
    output logic [31:0]   bRData,
    output logic [AW-1:0] mAddr,
    output logic          mWrite,
    output logic [31:0]   mWData,
    input  logic [31:0]   mRData,
    output logic          busy,
    output logic          done
);

    state_t        state, stateNext;
    logic [AW-1:0] wordAddr, engAddr;
    logic          busRam, csrWrite, startCmd, clrCmd;
    logic          engReq, engWrite, grant;
    logic [2:0]    idx, capIdx;
    logic [1:0]    k;
    logic          capV, doneFlag, csrSel;
    logic [31:0]   csrWord, csrSnap, dotOut;
    logic [31:0]   opnd [8];
    logic          unusedAddrBits;

    assign wordAddr       = bAddr[AW-1:0];
    assign unusedAddrBits = ^bAddr[31:AW];
    assign busRam         = bValid && (wordAddr != CSR_ADDR);
    assign csrWrite       = bValid && bWrite && (wordAddr == CSR_ADDR);
    assign startCmd       = csrWrite && bWData[CSR_START_BIT] && (state == IDLE);
    assign clrCmd         = csrWrite && bWData[CSR_CLR_BIT];
    assign engReq         = (state == LOAD) || (state == STORE);
    assign grant          = engReq && !busRam;
    assign busy           = (state != IDLE);
    assign done           = doneFlag;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        engWrite  = 1'b0;
        engAddr   = '0;
        case (state)
            IDLE:  if (startCmd) stateNext = LOAD;
            LOAD: begin
                engAddr = idx[2] ? B_BASE + AW'(idx[1:0]) : A_BASE + AW'(idx[1:0]);
                if (grant && idx == 3'd7) stateNext = WAIT;
            end
            WAIT:  stateNext = STORE;
            STORE: begin
                engWrite = 1'b1;
                engAddr  = C_BASE + AW'(k);
                if (grant && k == 2'd3) stateNext = DONE;
            end
            DONE:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        csrWord               = '0;
        csrWord[CSR_BUSY_BIT] = busy;
        csrWord[CSR_DONE_BIT] = doneFlag;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            k        <= '0;
            capV     <= 1'b0;
            capIdx   <= '0;
            doneFlag <= 1'b0;
            csrSel   <= 1'b0;
            csrSnap  <= '0;
        end else begin
            // RAM q arrives one cycle after the granted read, so the slot index travels with it
            capV   <= (state == LOAD) && grant;
            capIdx <= idx;
            if (startCmd)                        idx <= '0;
            else if (state == LOAD && grant)     idx <= idx + 3'd1;
            if (state == WAIT)                   k <= '0;
            else if (state == STORE && grant)    k <= k + 2'd1;
            if (state == DONE)                   doneFlag <= 1'b1;
            else if (clrCmd || startCmd)         doneFlag <= 1'b0;
            if (bValid && !bWrite) begin
                csrSel  <= (wordAddr == CSR_ADDR);
                csrSnap <= csrWord;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capV) opnd[capIdx] <= mRData;
    end

    // k = {i, j}: row i of A (opnd 0..3) against column j of B (opnd 4..7)
    sm_matrix_dot2 uDot (
        .a0(opnd[{k[1], 1'b0}]),
        .b0(opnd[{2'b10, k[0]}]),
        .a1(opnd[{k[1], 1'b1}]),
        .b1(opnd[{2'b11, k[0]}]),
        .y (dotOut)
    );

    assign mAddr  = busRam ? wordAddr : engAddr;
    assign mWrite = busRam ? bWrite   : engWrite;
    assign mWData = busRam ? bWData   : dotOut;
    assign bRData = csrSel ? csrSnap  : mRData;

endmodule
